// File: rtl/cache_ctrl_pkg.sv
// Shared types, constants and width helpers for the set-associative cache controller.
package cache_ctrl_pkg;

   // Controller states
   typedef enum logic [1:0] {
      CHECK     = 2'd0,
      WRITEBACK = 2'd1,
      FILL      = 2'd2
   } state_t;

   // Data array input select
   localparam logic [1:0] DSEL_FILL = 2'b00;
   localparam logic [1:0] DSEL_CPU  = 2'b01;
   localparam logic [1:0] DSEL_NONE = 2'b11;

   // Width of a way index; never narrower than one bit
   function automatic int unsigned way_idx_w(input int unsigned ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

endpackage

// File: rtl/plru_array.sv
// Per-set tree pseudo-LRU storage with victim lookup and touch-update port.
module plru_array
   import cache_ctrl_pkg::*;
#(
   parameter int unsigned WAYS    = 4,
   parameter int unsigned S_INDEX = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [S_INDEX-1:0]         index,
   output logic [way_idx_w(WAYS)-1:0] victim,
   input  logic                       upd_en,
   input  logic [way_idx_w(WAYS)-1:0] upd_way
);

   localparam int unsigned LVL  = way_idx_w(WAYS);
   localparam int unsigned SETS = 2 ** S_INDEX;

   // Tree nodes 0..WAYS-2 (root 0, children 2n+1/2n+2); top slot is padding held at 0
   logic [WAYS-1:0] plru_q [SETS];
   logic [WAYS-1:0] cur;
   logic [WAYS-1:0] nxt;
   logic [LVL-1:0]  node_v;
   logic [LVL-1:0]  node_u;
   logic [LVL-1:0]  way_sh;
   logic            bit_v;
   logic            dir_u;

   assign cur = plru_q[index];

   // Victim walk: each node bit picks the child the victim lies under (0 = left)
   always_comb begin
      victim = '0;
      node_v = '0;
      bit_v  = 1'b0;
      for (int l = 0; l < LVL; l++) begin
         bit_v  = cur[node_v];
         victim = LVL'({victim, bit_v});
         node_v = LVL'({node_v, 1'b0}) + LVL'(1) + LVL'(bit_v);
      end
   end

   // Touch: along the accessed way's path, point every node at the other subtree
   always_comb begin
      nxt    = cur;
      node_u = '0;
      way_sh = upd_way;
      dir_u  = 1'b0;
      for (int l = 0; l < LVL; l++) begin
         dir_u       = way_sh[LVL-1];
         nxt[node_u] = ~dir_u;
         node_u      = LVL'({node_u, 1'b0}) + LVL'(1) + LVL'(dir_u);
         way_sh      = LVL'({way_sh, 1'b0});
      end
      nxt[WAYS-1] = 1'b0;
   end

   // PLRU state storage, cleared on reset
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            plru_q[s] <= '0;
         end
      end else if (upd_en) begin
         plru_q[index] <= nxt;
      end
   end

endmodule

// File: rtl/assoc_cache_control.sv
// Control FSM for an N-way set-associative write-back, write-allocate cache.
module assoc_cache_control
   import cache_ctrl_pkg::*;
#(
   parameter int unsigned WAYS    = 4,
   parameter int unsigned S_INDEX = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       mem_read,
   input  logic                       mem_write,
   input  logic [S_INDEX-1:0]         mem_index,
   output logic                       mem_resp,
   output logic                       pmem_read,
   output logic                       pmem_write,
   input  logic                       pmem_resp,
   input  logic [WAYS-1:0]            way_hit,
   input  logic [WAYS-1:0]            way_valid,
   input  logic [WAYS-1:0]            way_dirty,
   output logic [WAYS-1:0]            tag_load,
   output logic [WAYS-1:0]            valid_load,
   output logic [WAYS-1:0]            dirty_load,
   output logic                       dirty_in,
   output logic [WAYS-1:0]            data_we,
   output logic [1:0]                 data_sel,
   output logic                       addr_sel,
   output logic [way_idx_w(WAYS)-1:0] victim_way
);

   localparam int unsigned WW = way_idx_w(WAYS);

   state_t          state_q;
   state_t          state_d;
   logic [WW-1:0]   victim_q;
   logic [WW-1:0]   victim_d;

   logic            req;
   logic            hit_any;
   logic [WW-1:0]   hit_idx;
   logic [WAYS-1:0] hit_oh;
   logic            inv_any;
   logic [WW-1:0]   inv_idx;
   logic [WW-1:0]   miss_victim;
   logic [WW-1:0]   plru_victim;
   logic [WAYS-1:0] victim_oh;
   logic            plru_upd;
   logic [WW-1:0]   plru_way;

   assign req       = mem_read | mem_write;
   assign hit_any   = |way_hit;
   assign inv_any   = ~&way_valid;
   assign hit_oh    = WAYS'(1) << hit_idx;
   assign victim_oh = WAYS'(1) << victim_q;

   // Lowest-index hit way and lowest-index invalid way
   always_comb begin
      hit_idx = '0;
      inv_idx = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (way_hit[i]) begin
            hit_idx = WW'(i);
         end
         if (!way_valid[i]) begin
            inv_idx = WW'(i);
         end
      end
   end

   // Invalid ways are filled before anything is evicted
   assign miss_victim = inv_any ? inv_idx : plru_victim;

   plru_array #(
      .WAYS    (WAYS),
      .S_INDEX (S_INDEX)
   ) u_plru (
      .clk     (clk),
      .rst     (rst),
      .index   (mem_index),
      .victim  (plru_victim),
      .upd_en  (plru_upd),
      .upd_way (plru_way)
   );

   // State and latched victim registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= CHECK;
         victim_q <= '0;
      end else begin
         state_q  <= state_d;
         victim_q <= victim_d;
      end
   end

   // Next-state and datapath control decode
   always_comb begin
      state_d    = state_q;
      victim_d   = victim_q;
      mem_resp   = 1'b0;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      tag_load   = '0;
      valid_load = '0;
      dirty_load = '0;
      dirty_in   = 1'b0;
      data_we    = '0;
      data_sel   = DSEL_NONE;
      addr_sel   = 1'b0;
      victim_way = victim_q;
      plru_upd   = 1'b0;
      plru_way   = victim_q;

      unique case (state_q)
         CHECK: begin
            if (req) begin
               if (hit_any) begin
                  mem_resp = 1'b1;
                  plru_upd = 1'b1;
                  plru_way = hit_idx;
                  // Write takes priority when both request lines are raised
                  if (mem_write) begin
                     data_we    = hit_oh;
                     data_sel   = DSEL_CPU;
                     dirty_load = hit_oh;
                     dirty_in   = 1'b1;
                  end
               end else begin
                  victim_d = miss_victim;
                  if (way_valid[miss_victim] && way_dirty[miss_victim]) begin
                     state_d = WRITEBACK;
                  end else begin
                     state_d = FILL;
                  end
               end
            end
         end

         WRITEBACK: begin
            pmem_write = 1'b1;
            addr_sel   = 1'b1;
            if (pmem_resp) begin
               state_d = FILL;
            end
         end

         FILL: begin
            pmem_read = 1'b1;
            data_sel  = DSEL_FILL;
            if (pmem_resp) begin
               data_we    = victim_oh;
               tag_load   = victim_oh;
               valid_load = victim_oh;
               dirty_load = victim_oh;
               plru_upd   = 1'b1;
               state_d    = CHECK;
            end
         end

         default: begin
            state_d = CHECK;
         end
      endcase
   end

   // Datapath must never report more than one matching way
   hit_onehot_a: assert property (@(posedge clk) disable iff (rst)
      (req && state_q == CHECK) |-> $onehot0(way_hit));

endmodule
